// File: rtl/adder_arbiter_pkg.sv
// Shared defaults and the round-robin search helper for the shared-adder arbiter.
// Requester count is bounded by MAX_REQ so the search can use fixed-width vectors.
package adder_arbiter_pkg;

  localparam int unsigned DEF_BUS_SIZE = 32;
  localparam int unsigned DEF_NUM_REQ  = 4;
  localparam int unsigned MAX_REQ      = 8;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // First set request at or above ptr, wrapping modulo n (n <= MAX_REQ).
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                       input logic [2:0]         ptr,
                                       input int unsigned        n);
    rr_pick_t    r;
    int unsigned idx;
    r = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      idx = (32'(ptr) + i) % n;
      if (i < n && !r.found && req[idx[2:0]]) begin
        r.found = 1'b1;
        r.idx   = idx[2:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/adder_arbiter_if.sv
// Request/result bundle between requesters, result consumer and the shared adder.
// Signal names keep the legacy port names so existing hookups map one-to-one.
interface adder_arbiter_if
  import adder_arbiter_pkg::*;
#(
  parameter int unsigned BUS_SIZE = DEF_BUS_SIZE,
  parameter int unsigned NUM_REQ  = DEF_NUM_REQ
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]          i_req;
  logic [NUM_REQ*BUS_SIZE-1:0] i_a;
  logic [NUM_REQ*BUS_SIZE-1:0] i_b;
  logic [NUM_REQ-1:0]          o_grant;
  logic                        o_valid;
  logic [BUS_SIZE-1:0]         o_sum;
  logic [ID_W-1:0]             o_id;
  logic                        i_ready;

  modport master (
    output i_req, i_a, i_b, i_ready,
    input  o_grant, o_valid, o_sum, o_id
  );

  modport slave (
    input  i_req, i_a, i_b, i_ready,
    output o_grant, o_valid, o_sum, o_id
  );

endinterface

// File: rtl/adder_arbiter_adder.sv
// Plain modular adder: carry-out dropped, no signed interpretation.
module adder #(
  parameter int unsigned BUS_SIZE = 32
) (
  input  logic [BUS_SIZE-1:0] a_i,
  input  logic [BUS_SIZE-1:0] b_i,
  output logic [BUS_SIZE-1:0] sum_o
);

  assign sum_o = a_i + b_i;

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin shares one adder among NUM_REQ requesters through a 2-stage
// pipeline; results leave tagged with the requester id over valid/ready.
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int unsigned BUS_SIZE = DEF_BUS_SIZE,
  parameter int unsigned NUM_REQ  = DEF_NUM_REQ
) (
  input logic            i_clk,
  input logic            i_reset,
  adder_arbiter_if.slave bus
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic                advance1;
  logic                advance2;
  logic [MAX_REQ-1:0]  req_ext;
  logic [2:0]          ptr_ext;
  rr_pick_t            pick;
  logic                grant_any;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     gnt_id;
  logic [ID_W-1:0]     ptr_d;
  logic [BUS_SIZE-1:0] a_sel;
  logic [BUS_SIZE-1:0] b_sel;
  logic [BUS_SIZE-1:0] sum;

  logic                s1_valid_q;
  logic [BUS_SIZE-1:0] s1_a_q;
  logic [BUS_SIZE-1:0] s1_b_q;
  logic [ID_W-1:0]     s1_id_q;
  logic                o_valid_q;
  logic [BUS_SIZE-1:0] o_sum_q;
  logic [ID_W-1:0]     o_id_q;
  logic [ID_W-1:0]     rr_ptr_q;

  assign advance2 = !o_valid_q || bus.i_ready;
  assign advance1 = !s1_valid_q || advance2;

  always_comb begin
    req_ext              = '0;
    req_ext[NUM_REQ-1:0] = bus.i_req;
    ptr_ext              = '0;
    ptr_ext[ID_W-1:0]    = rr_ptr_q;
    pick                 = rr_pick(req_ext, ptr_ext, NUM_REQ);
    // Narrow the 3-bit search index to ID_W by match so no index bit is left dangling.
    gnt_id = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (pick.idx == 3'(k)) gnt_id = ID_W'(k);
    end
    grant_any = pick.found && advance1 && !i_reset;
    grant     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      grant[k] = grant_any && (gnt_id == ID_W'(k));
    end
    ptr_d = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
    a_sel = bus.i_a[gnt_id*BUS_SIZE +: BUS_SIZE];
    b_sel = bus.i_b[gnt_id*BUS_SIZE +: BUS_SIZE];
  end

  adder #(.BUS_SIZE(BUS_SIZE)) u_adder (
    .a_i  (s1_a_q),
    .b_i  (s1_b_q),
    .sum_o(sum)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_id_q    <= '0;
      o_valid_q  <= 1'b0;
      o_sum_q    <= '0;
      o_id_q     <= '0;
      rr_ptr_q   <= '0;
    end else begin
      if (advance2) begin
        o_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          o_sum_q <= sum;
          o_id_q  <= s1_id_q;
        end
      end
      if (advance1) begin
        s1_valid_q <= grant_any;
        if (grant_any) begin
          s1_a_q  <= a_sel;
          s1_b_q  <= b_sel;
          s1_id_q <= gnt_id;
        end
      end
      if (grant_any) rr_ptr_q <= ptr_d;
    end
  end

  assign bus.o_grant = grant;
  assign bus.o_valid = o_valid_q;
  assign bus.o_sum   = o_sum_q;
  assign bus.o_id    = o_id_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: directed scenarios with literal expectations plus a
// long randomized run, all checked against a queue-based model of in-flight ops.
module tb_adder_arbiter;
  import adder_arbiter_pkg::*;

  localparam int unsigned BW = 32;
  localparam int unsigned NR = 4;
  localparam int unsigned IW = 2;

  typedef struct {
    logic [IW-1:0] id;
    logic [BW-1:0] sum;
    int            rdy;
  } item_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  adder_arbiter_if #(.BUS_SIZE(BW), .NUM_REQ(NR)) bus ();

  adder_arbiter #(.BUS_SIZE(BW), .NUM_REQ(NR)) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus)
  );

  // stimulus state
  logic [NR-1:0] req_v;
  logic [BW-1:0] opa [NR];
  logic [BW-1:0] opb [NR];
  logic          ready_v;
  logic          rst_v;

  // values sampled by the most recent step
  logic [NR-1:0] s_grant;
  logic          s_valid;
  logic [BW-1:0] s_sum;
  logic [IW-1:0] s_id;

  // reference model
  item_t q[$];
  int    mptr;
  int    cyc;
  int    ops;

  int checks;
  int errors;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [BW-1:0] rnd();
    case ($urandom_range(0, 7))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h0;
      2:       return 32'h8000_0000;
      default: return $urandom();
    endcase
  endfunction

  // Apply inputs, compare at negedge, advance the model past the next posedge.
  task automatic step();
    logic [NR-1:0] eg;
    logic          exp_valid;
    item_t         it;
    rst         = rst_v;
    bus.i_req   = req_v;
    bus.i_ready = ready_v;
    for (int k = 0; k < int'(NR); k++) begin
      bus.i_a[k*BW +: BW] = opa[k];
      bus.i_b[k*BW +: BW] = opb[k];
    end
    @(negedge clk);
    s_grant = bus.o_grant;
    s_valid = bus.o_valid;
    s_sum   = bus.o_sum;
    s_id    = bus.o_id;

    eg = '0;
    if (!rst_v && (q.size() < 2 || ready_v)) begin
      for (int i = 0; i < int'(NR); i++) begin
        int k;
        k = (mptr + i) % int'(NR);
        if (eg == '0 && req_v[k]) eg[k] = 1'b1;
      end
    end
    exp_valid = (q.size() > 0) && (q[0].rdy <= cyc);

    chk("grant", 64'(s_grant), 64'(eg));
    chk("grant_onehot0", 64'($onehot0(s_grant)), 64'd1);
    chk("valid", 64'(s_valid), 64'(exp_valid));
    if (exp_valid && s_valid) begin
      chk("sum", 64'(s_sum), 64'(q[0].sum));
      chk("id", 64'(s_id), 64'(q[0].id));
    end

    if (rst_v) begin
      q.delete();
      mptr = 0;
    end else begin
      if (exp_valid && ready_v) void'(q.pop_front());
      for (int k = 0; k < int'(NR); k++) begin
        if (eg[k]) begin
          it.id  = IW'(k);
          it.sum = opa[k] + opb[k];
          it.rdy = cyc + 2;
          q.push_back(it);
          mptr = (k + 1) % int'(NR);
          ops++;
        end
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst_v = 1'b1;
    req_v = '0;
    step();
    rst_v = 1'b0;
  endtask

  logic [NR-1:0] g   [12];
  logic          vv  [12];
  logic [BW-1:0] sm  [12];
  logic [IW-1:0] ids [12];
  logic [NR-1:0] exp_g [5];

  initial begin
    checks  = 0;
    errors  = 0;
    cyc     = 0;
    ops     = 0;
    mptr    = 0;
    req_v   = '0;
    ready_v = 1'b1;
    rst_v   = 1'b1;
    for (int k = 0; k < int'(NR); k++) begin
      opa[k] = '0;
      opb[k] = '0;
    end

    // 1) reset values, single request from requester 2
    step();
    step();
    chk("rst_valid", 64'(s_valid), 64'd0);
    chk("rst_sum", 64'(s_sum), 64'd0);
    chk("rst_id", 64'(s_id), 64'd0);
    chk("rst_grant", 64'(s_grant), 64'd0);
    rst_v  = 1'b0;
    req_v  = 4'b0100;
    opa[2] = 32'd5;
    opb[2] = 32'd7;
    step();
    chk("t1_grant", 64'(s_grant), 64'b0100);
    req_v = '0;
    step();
    chk("t1_valid_t1", 64'(s_valid), 64'd0);
    step();
    chk("t1_valid_t2", 64'(s_valid), 64'd1);
    chk("t1_sum", 64'(s_sum), 64'd12);
    chk("t1_id", 64'(s_id), 64'd2);
    step();

    // 2) all requesters held, ready high: strict rotation, no bubbles
    reset_pulse();
    req_v   = 4'hF;
    ready_v = 1'b1;
    for (int k = 0; k < int'(NR); k++) begin
      opa[k] = 32'(100 * k);
      opb[k] = 32'(k);
    end
    for (int i = 0; i < 7; i++) begin
      step();
      g[i]   = s_grant;
      vv[i]  = s_valid;
      sm[i]  = s_sum;
      ids[i] = s_id;
    end
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int i = 0; i < 5; i++) begin
      chk("t2_grant_seq", 64'(g[i]), 64'(exp_g[i]));
      chk("t2_no_bubble", 64'(vv[i+2]), 64'd1);
      chk("t2_id_seq", 64'(ids[i+2]), 64'(i % 4));
    end
    chk("t2_sum1", 64'(sm[3]), 64'd101);
    req_v = '0;
    step();
    step();

    // 3) wraparound arithmetic
    reset_pulse();
    req_v  = 4'b0001;
    opa[0] = 32'hFFFF_FFFF;
    opb[0] = 32'h1;
    step();
    req_v = '0;
    step();
    step();
    chk("t3_wrap1_valid", 64'(s_valid), 64'd1);
    chk("t3_wrap1_sum", 64'(s_sum), 64'd0);
    req_v  = 4'b0001;
    opa[0] = 32'h8000_0000;
    opb[0] = 32'h8000_0000;
    step();
    req_v = '0;
    step();
    step();
    chk("t3_wrap2_valid", 64'(s_valid), 64'd1);
    chk("t3_wrap2_sum", 64'(s_sum), 64'd0);
    step();

    // 4) backpressure: pipe fills, outputs freeze, grants stop
    reset_pulse();
    ready_v = 1'b0;
    req_v   = 4'b0111;
    for (int k = 0; k < int'(NR); k++) begin
      opa[k] = 32'(k + 1);
      opb[k] = 32'd10;
    end
    for (int i = 0; i < 9; i++) begin
      if (i == 6) ready_v = 1'b1;
      step();
      g[i]   = s_grant;
      vv[i]  = s_valid;
      sm[i]  = s_sum;
      ids[i] = s_id;
      req_v  = req_v & ~s_grant;
    end
    chk("t4_g0", 64'(g[0]), 64'b0001);
    chk("t4_g1", 64'(g[1]), 64'b0010);
    for (int i = 2; i < 6; i++) begin
      chk("t4_stall_grant", 64'(g[i]), 64'd0);
      chk("t4_stall_valid", 64'(vv[i]), 64'd1);
      chk("t4_stall_sum", 64'(sm[i]), 64'd11);
      chk("t4_stall_id", 64'(ids[i]), 64'd0);
    end
    chk("t4_refill_grant", 64'(g[6]), 64'b0100);
    chk("t4_id6", 64'(ids[6]), 64'd0);
    chk("t4_id7", 64'(ids[7]), 64'd1);
    chk("t4_sum7", 64'(sm[7]), 64'd12);
    chk("t4_id8", 64'(ids[8]), 64'd2);
    chk("t4_valid8", 64'(vv[8]), 64'd1);
    req_v = '0;
    step();
    step();

    // 5) reset with both stages full
    reset_pulse();
    ready_v = 1'b0;
    req_v   = 4'b0011;
    step();
    req_v = req_v & ~s_grant;
    step();
    req_v = 4'b1001;
    rst_v = 1'b1;
    step();
    chk("t5_grant_in_reset", 64'(s_grant), 64'd0);
    rst_v   = 1'b0;
    ready_v = 1'b1;
    step();
    chk("t5_valid_after_reset", 64'(s_valid), 64'd0);
    chk("t5_first_grant", 64'(s_grant), 64'b0001);
    req_v = req_v & ~s_grant;
    step();
    chk("t5_second_grant", 64'(s_grant), 64'b1000);
    req_v = '0;
    step();
    chk("t5_result_id", 64'(s_id), 64'd0);
    step();
    step();

    // 6) randomized traffic
    ops = 0;
    begin
      int guard;
      guard = 0;
      while (ops < 10000 && guard < 60000) begin
        for (int k = 0; k < int'(NR); k++) begin
          if (s_grant[k]) begin
            req_v[k] = ($urandom_range(0, 3) != 0);
            opa[k]   = rnd();
            opb[k]   = rnd();
          end else if (!req_v[k]) begin
            if ($urandom_range(0, 1) == 1) begin
              req_v[k] = 1'b1;
              opa[k]   = rnd();
              opb[k]   = rnd();
            end
          end else if ($urandom_range(0, 15) == 0) begin
            req_v[k] = 1'b0;
          end
        end
        ready_v = ($urandom_range(0, 3) != 0);
        rst_v   = ($urandom_range(0, 499) == 0);
        step();
        guard++;
      end
      rst_v = 1'b0;
      if (ops < 10000) begin
        errors++;
        $display("FAIL random_budget: got %0d ops expected 10000 within %0d cycles", ops, guard);
      end
    end

    req_v   = '0;
    ready_v = 1'b1;
    for (int i = 0; i < 4; i++) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
